// File: rtl/alu_pkg.sv
// Opcode encodings shared by the ALU datapath units.
package alu_pkg;
  typedef logic [1:0] op_t;
  localparam op_t OP_ADD_WRAP = 2'b00;
  localparam op_t OP_ADD_SAT  = 2'b01;
  localparam op_t OP_SUB_SAT  = 2'b10;
  localparam op_t OP_LSAT     = 2'b11;
endpackage

// File: rtl/cla_group.sv
// Combinational carry-lookahead group: in-group carries plus
// group generate/propagate and carry-out.
module cla_group #(
  parameter int GROUP_W = 4
) (
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               g,
  output logic               p,
  output logic               cout
);
  logic [GROUP_W-1:0] gi;
  logic [GROUP_W-1:0] pi;
  logic [GROUP_W-1:0] c;

  always_comb begin
    gi   = a & b;
    pi   = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < GROUP_W; i++) begin
      c[i] = gi[i-1] | (pi[i-1] & c[i-1]);
    end
    g = 1'b0;
    p = 1'b1;
    for (int i = 0; i < GROUP_W; i++) begin
      g = gi[i] | (pi[i] & g);
      p = p & pi[i];
    end
  end

  assign sum  = pi ^ c;
  assign cout = g | (p & cin);
endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA add/sub with wrap, full-width and lane saturation.
// Stage k adds slice k; upper operands skew forward, sums align at end.
module cla_pipe_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int GROUP_W = 4,
  parameter int LANE_W  = 4,
  parameter int STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  op_t              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovfl,
  output logic             out_zero,
  output logic             out_neg
);
  localparam int SW  = WIDTH / STAGES;
  localparam int NG  = SW / GROUP_W;
  localparam int LPS = SW / LANE_W;
  localparam int L   = STAGES - 1;

  logic             adv;
  logic             valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, neg_q;
  logic [WIDTH-1:0] bp;

  assign adv      = ~valid_q | out_ready;
  assign in_ready = adv;
  assign bp       = (in_op == OP_SUB_SAT) ? ~in_b : in_b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SW;
    localparam int HI = LO + SW;
    logic [WIDTH-1:LO]    a_i, b_i;
    logic                 c_i, v_i;
    op_t                  op_i;
    logic [NG:0]          c;
    logic [SW-1:0]        raw, ss;
    logic [LPS-1:0]       lv;
    logic [HI-1:0]        s_o;
    logic [HI/LANE_W-1:0] lov_o;
    logic [NG-1:0]        g_unused, p_unused;

    if (k == 0) begin : g_in
      assign a_i   = in_a;
      assign b_i   = bp;
      assign c_i   = (in_op == OP_SUB_SAT);
      assign v_i   = in_valid & ~flush;
      assign op_i  = in_op;
      assign s_o   = ss;
      assign lov_o = lv;
    end else begin : g_reg
      logic                 v_q, c_q;
      op_t                  op_q;
      logic [WIDTH-1:LO]    a_q, b_q;
      logic [LO-1:0]        s_q;
      logic [LO/LANE_W-1:0] lov_q;

      always_ff @(posedge clk) begin
        if (rst || flush) v_q <= 1'b0;
        else if (adv)     v_q <= g_stg[k-1].v_i;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          c_q   <= g_stg[k-1].c[NG];
          op_q  <= g_stg[k-1].op_i;
          a_q   <= g_stg[k-1].a_i[WIDTH-1:LO];
          b_q   <= g_stg[k-1].b_i[WIDTH-1:LO];
          s_q   <= g_stg[k-1].s_o;
          lov_q <= g_stg[k-1].lov_o;
        end
      end

      assign a_i   = a_q;
      assign b_i   = b_q;
      assign c_i   = c_q;
      assign v_i   = v_q;
      assign op_i  = op_q;
      assign s_o   = {ss, s_q};
      assign lov_o = {lv, lov_q};
    end

    assign c[0] = c_i;
    for (genvar j = 0; j < NG; j++) begin : g_grp
      localparam int B = LO + j * GROUP_W;
      logic cin;
      // Lane boundaries kill the incoming carry in lane mode
      if (B % LANE_W == 0) begin : g_kill
        assign cin = (op_i == OP_LSAT) ? 1'b0 : c[j];
      end else begin : g_pass
        assign cin = c[j];
      end
      cla_group #(.GROUP_W(GROUP_W)) u_grp (
        .a    (a_i[B +: GROUP_W]),
        .b    (b_i[B +: GROUP_W]),
        .cin  (cin),
        .sum  (raw[j*GROUP_W +: GROUP_W]),
        .g    (g_unused[j]),
        .p    (p_unused[j]),
        .cout (c[j+1])
      );
    end

    for (genvar l = 0; l < LPS; l++) begin : g_lane
      localparam int M = l * LANE_W + LANE_W - 1;
      logic am, bm;
      assign am    = a_i[LO+M];
      assign bm    = b_i[LO+M];
      assign lv[l] = (am == bm) && (raw[M] != am);
      assign ss[l*LANE_W +: LANE_W] =
        (op_i == OP_LSAT && lv[l]) ? {am, {(LANE_W-1){~am}}}
                                   : raw[l*LANE_W +: LANE_W];
    end

    if (k == L) begin : g_last
      logic c_unused;
      assign c_unused = c[NG];
    end
  end

  logic a_m, b_m, s_m, vfull;
  op_t  op_l;

  assign op_l = g_stg[L].op_i;
  assign a_m  = g_stg[L].a_i[WIDTH-1];
  assign b_m  = g_stg[L].b_i[WIDTH-1];
  assign s_m  = g_stg[L].s_o[WIDTH-1];

  always_comb begin
    vfull  = (a_m == b_m) && (s_m != a_m);
    sum_d  = g_stg[L].s_o;
    ovfl_d = vfull;
    unique case (1'b1)
      op_l == OP_ADD_WRAP: ;
      op_l == OP_LSAT: ovfl_d = |g_stg[L].lov_o;
      op_l == OP_ADD_SAT,
      op_l == OP_SUB_SAT: begin
        if (vfull) sum_d = {a_m, {(WIDTH-1){~a_m}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      if (flush)    valid_q <= 1'b0;
      else if (adv) valid_q <= g_stg[L].v_i;
      if (adv && g_stg[L].v_i && !flush) begin
        sum_q  <= sum_d;
        ovfl_q <= ovfl_d;
        zero_q <= (sum_d == '0);
        neg_q  <= sum_d[WIDTH-1];
      end
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_ovfl  = ovfl_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench: three depths (1, 2, 4) share one stimulus stream,
// each with its own expected-result queue and output monitor.
module tb_cla_pipe_addsub;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] sum;
    logic        ovfl;
    logic        zero;
    logic        neg;
    int          acc;
    bit          strict;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  op = '0;
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;
  bit          strict = 1'b0;
  bit          done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int stg,
                     input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s stg=%0d got=%h want=%h t=%0t", nm, stg, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [15:0] v, input int w);
    int u;
    u = int'(v) & ((1 << w) - 1);
    return (u >= (1 << (w - 1))) ? u - (1 << w) : u;
  endfunction

  function automatic int clamp(input int r, input int w, output bit ov);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    ov = (r > hi) || (r < lo);
    return (r > hi) ? hi : (r < lo) ? lo : r;
  endfunction

  // Signed-arithmetic reference: no carries, just integer sums and clamps
  function automatic exp_t model(input logic [15:0] xa, xb, input logic [1:0] xop);
    exp_t e;
    int   r, c, t;
    bit   ov;
    e = '{default: 0};
    case (xop)
      OP_ADD_WRAP: begin
        r = sx(xa, 16) + sx(xb, 16);
        void'(clamp(r, 16, ov));
        t = r;
        e.sum  = t[15:0];
        e.ovfl = ov;
      end
      OP_ADD_SAT, OP_SUB_SAT: begin
        r = (xop == OP_ADD_SAT) ? sx(xa, 16) + sx(xb, 16)
                                : sx(xa, 16) - sx(xb, 16);
        t = clamp(r, 16, ov);
        e.sum  = t[15:0];
        e.ovfl = ov;
      end
      default: begin
        e.ovfl = 1'b0;
        for (int i = 0; i < 4; i++) begin
          r = sx(xa >> (4 * i), 4) + sx(xb >> (4 * i), 4);
          c = clamp(r, 4, ov);
          e.sum[4*i +: 4] = c[3:0];
          e.ovfl = e.ovfl | ov;
        end
      end
    endcase
    e.zero = (e.sum == 16'h0000);
    e.neg  = e.sum[15];
    return e;
  endfunction

  for (genvar d = 0; d < 3; d++) begin : g_dut
    localparam int STG = (d == 0) ? 1 : (d == 1) ? 2 : 4;
    logic        rdy, ov, ovfl, zero, neg;
    logic [15:0] sum;
    logic [15:0] held = '0;
    bit          prev_rst = 1'b0;
    bit          prev_flush = 1'b0;
    bit          hold = 1'b0;
    exp_t        q[$];

    cla_pipe_addsub #(
      .WIDTH(16), .GROUP_W(4), .LANE_W(4), .STAGES(STG)
    ) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy),
      .in_a(a), .in_b(b), .in_op(op),
      .out_valid(ov), .out_ready(out_ready),
      .out_sum(sum), .out_ovfl(ovfl), .out_zero(zero), .out_neg(neg)
    );

    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        q.delete();
        prev_rst   = 1'b1;
        prev_flush = 1'b0;
        hold       = 1'b0;
      end else begin
        if (prev_rst) begin
          chk("rst_valid", STG, 32'(ov), 0);
          chk("rst_sum", STG, 32'(sum), 0);
          chk("rst_flags", STG, 32'({ovfl, zero, neg}), 0);
          chk("rst_ready", STG, 32'(rdy), 1);
        end
        if (prev_flush) chk("flush_valid", STG, 32'(ov), 0);
        if (hold) chk("hold_sum", STG, 32'(sum), 32'(held));
        if (ov && out_ready) begin
          if (q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_out stg=%0d got=%h want=none", STG, sum);
          end else begin
            e = q.pop_front();
            chk("sum", STG, 32'(sum), 32'(e.sum));
            chk("ovfl", STG, 32'(ovfl), 32'(e.ovfl));
            chk("zero", STG, 32'(zero), 32'(e.zero));
            chk("neg", STG, 32'(neg), 32'(e.neg));
            if (e.strict) chk("latency", STG, 32'(cyc - e.acc), STG);
          end
        end
        if (flush) q.delete();
        else if (in_valid && rdy) begin
          e = model(a, b, op);
          e.acc    = cyc;
          e.strict = strict;
          q.push_back(e);
        end
        prev_rst   = 1'b0;
        prev_flush = flush;
        hold       = ov && !out_ready && !flush;
        held       = sum;
      end
    end
  end

  task automatic send(input logic [15:0] xa, xb, input logic [1:0] xop);
    bit ok = 1'b0;
    a = xa;
    b = xb;
    op = xop;
    in_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (g_dut[1].rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout got=no_ready want=ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic stall_chk(input string nm, input logic [31:0] want);
    chk(nm, 1, 32'(g_dut[0].rdy), want);
    chk(nm, 2, 32'(g_dut[1].rdy), want);
    chk(nm, 4, 32'(g_dut[2].rdy), want);
  endtask

  initial begin
    #2000000;
    nerr++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    idle(3);
    rst = 1'b0;
    strict = 1'b1;
    send(16'h7FFF, 16'h0001, OP_ADD_WRAP);
    send(16'h7FFF, 16'h0001, OP_ADD_SAT);
    send(16'h8000, 16'hFFFF, OP_ADD_SAT);
    send(16'h1234, 16'h0001, OP_ADD_SAT);
    send(16'h8000, 16'h0001, OP_SUB_SAT);
    send(16'h7FFF, 16'hFFFF, OP_SUB_SAT);
    send(16'h0005, 16'h0005, OP_SUB_SAT);
    send(16'h7F18, 16'h1119, OP_LSAT);
    send(16'h0000, 16'h8000, OP_SUB_SAT);
    idle(8);
    strict = 1'b0;

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(16'h1000 * 16'(i) + 16'h0101, 16'h0F0F, 2'(i));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          stall_chk("stall_in_ready", 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        stall_chk("resume_in_ready", 1);
      end
    join
    idle(8);

    send(16'h0102, 16'h0304, OP_ADD_WRAP);
    send(16'h0506, 16'h0708, OP_ADD_SAT);
    flush = 1'b1;
    in_valid = 1'b1;
    a = 16'hDEAD;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    idle(8);

    send(16'h1111, 16'h2222, OP_ADD_WRAP);
    send(16'h3333, 16'h4444, OP_LSAT);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(16'h4000, 16'h4000, OP_ADD_SAT);
    idle(8);

    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 39) == 0) begin
            flush = 1'b1;
            in_valid = 1'($urandom);
            idle(1);
            flush = 1'b0;
            in_valid = 1'b0;
          end
          send(pick(), pick(), 2'($urandom));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    idle(12);
    chk("drain", 1, 32'(g_dut[0].q.size()), 0);
    chk("drain", 2, 32'(g_dut[1].q.size()), 0);
    chk("drain", 4, 32'(g_dut[2].q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
